// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read master and one write master among NREQ requesters.
// Latency: req_i strobe -> master start 2 cycles best case; master done -> ack_o exactly 1 cycle.
// Backpressure: one command in flight; others wait in per-requester pending bits. Optional WAIT timeout: AXIL_ARB_TIMEOUT_EN.
module axil_master_arbiter #(
    parameter int NREQ           = 4,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         reqWrite_i,
    input  logic [NREQ*ADDR_W-1:0]  reqAddr_i,
    input  logic [NREQ*DATA_W-1:0]  reqData_i,
    output logic [NREQ-1:0]         ack_o,
    output logic [DATA_W-1:0]       rdData_o,
    output logic [1:0]              respCode_o,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] grantIdx_o,
    output logic                    rdStart_o,
    output logic [ADDR_W-1:0]       rdAddr_o,
    input  logic                    rdDone_i,
    input  logic [DATA_W-1:0]       rdData_i,
    input  logic [1:0]              rdResp_i,
    output logic                    wrStart_o,
    output logic [ADDR_W-1:0]       wrAddr_o,
    output logic [DATA_W-1:0]       wrData_o,
    input  logic                    wrDone_i,
    input  logic [1:0]              wrResp_i,
    output logic                    mstRst_o
);
    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [NREQ-1:0]   r_pending;
    logic [IW-1:0]     r_last;
    logic [IW-1:0]     r_grant;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_resp;

    logic              w_found;
    logic [IW-1:0]     w_pick;
    logic [IW:0]       w_sum;
    logic              w_load;
    logic              w_done;
    logic              w_timeout;
    logic [NREQ-1:0]   w_pick_oh;
    logic [NREQ-1:0]   w_grant_oh;
    logic [NREQ-1:0]   w_busy_mask;

    assign w_done      = r_write ? wrDone_i : rdDone_i;
    assign w_pick_oh   = NREQ'(1) << w_pick;
    assign w_grant_oh  = NREQ'(1) << r_grant;
    // A strobe from a requester that is already queued or currently in ISSUE/WAIT is dropped;
    // the acked requester may re-strobe during RESP.
    assign w_busy_mask = r_pending |
                         (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ? w_grant_oh : '0);

    // Round-robin search: first pending bit starting just after the last granted index
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_last} + IW1'(i + 1);
            if (w_sum >= IW1'(NREQ)) w_sum = w_sum - IW1'(NREQ);
            if (!w_found && r_pending[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // FSM next state and grant-load strobe
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (w_done || w_timeout) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Pending bits, latched command, captured response and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_last    <= IW'(NREQ - 1);
            r_grant   <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            r_pending <= (r_pending & ~(w_load ? w_pick_oh : '0)) | (req_i & ~w_busy_mask);
            if (w_load) begin
                r_grant <= w_pick;
                r_write <= reqWrite_i[w_pick];
                r_addr  <= reqAddr_i[w_pick*ADDR_W +: ADDR_W];
                r_wdata <= reqData_i[w_pick*DATA_W +: DATA_W];
            end
            if (r_state == ST_WAIT) begin
                if (w_done) begin
                    r_rdata <= r_write ? '0 : rdData_i;
                    r_resp  <= r_write ? wrResp_i : rdResp_i;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_resp  <= 2'b11;
                end
            end
            if (r_state == ST_RESP) r_last <= r_grant;
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_mst_rst;

    // Give up after TIMEOUT_CYCLES WAIT cycles without the expected done strobe
    assign w_timeout = (r_state == ST_WAIT) && !w_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign mstRst_o  = r_mst_rst;

    // WAIT-cycle counter and one-cycle master reset pulse (coincides with the error ack)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_mst_rst <= 1'b0;
        end else begin
            r_mst_rst <= w_timeout;
            if (r_state == ST_ISSUE)     r_cnt <= '0;
            else if (r_state == ST_WAIT) r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mstRst_o  = 1'b0;
`endif

    assign busy_o     = (r_state != ST_IDLE);
    assign grantIdx_o = r_grant;
    assign rdStart_o  = (r_state == ST_ISSUE) && !r_write;
    assign wrStart_o  = (r_state == ST_ISSUE) && r_write;
    assign rdAddr_o   = r_addr;
    assign wrAddr_o   = r_addr;
    assign wrData_o   = r_wdata;
    assign ack_o      = (r_state == ST_RESP) ? w_grant_oh : '0;
    assign rdData_o   = (r_state == ST_RESP) ? r_rdata : '0;
    assign respCode_o = (r_state == ST_RESP) ? r_resp : 2'b00;

`ifndef SYNTHESIS
    // Done strobes straight after a reset belong to a dropped transaction and are not flagged
    logic r_chk_quiet;

    // Protocol checks on requester strobes and master done strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chk_quiet <= 1'b1;
        end else begin
            if (r_state == ST_ISSUE) r_chk_quiet <= 1'b0;
            assert (NREQ >= 2 && NREQ <= 16 && TIMEOUT_CYCLES > 0)
                else $error("axil_master_arbiter: bad parameters");
            assert ((req_i & w_busy_mask) == '0)
                else $error("axil_master_arbiter: strobe from pending/granted requester %b", req_i);
            assert (r_state == ST_WAIT || r_chk_quiet || !(rdDone_i || wrDone_i))
                else $error("axil_master_arbiter: done strobe outside WAIT");
            assert (r_state != ST_WAIT || !(r_write ? rdDone_i : wrDone_i))
                else $error("axil_master_arbiter: done strobe of wrong direction");
        end
    end
`endif
endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a hand-driven read/write master model.
// Latency: checks start 2 cycles after strobe and ack 1 cycle after done.
// Backpressure: exercises queued requesters, round-robin order, reset mid-transaction and timeout.
module tb_axil_master_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_i = '0;
    logic [3:0]  reqWrite_i = '0;
    logic [15:0] reqAddr_i = '0;
    logic [127:0] reqData_i = '0;
    logic [3:0]  ack_o;
    logic [31:0] rdData_o;
    logic [1:0]  respCode_o;
    logic        busy_o;
    logic [1:0]  grantIdx_o;
    logic        rdStart_o;
    logic [3:0]  rdAddr_o;
    logic        rdDone_i = 1'b0;
    logic [31:0] rdData_i = '0;
    logic [1:0]  rdResp_i = '0;
    logic        wrStart_o;
    logic [3:0]  wrAddr_o;
    logic [31:0] wrData_o;
    logic        wrDone_i = 1'b0;
    logic [1:0]  wrResp_i = '0;
    logic        mstRst_o;

    int n_checks = 0;
    int n_fail   = 0;

    axil_master_arbiter #(
        .NREQ(4), .DATA_W(32), .ADDR_W(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .reqWrite_i(reqWrite_i), .reqAddr_i(reqAddr_i), .reqData_i(reqData_i),
        .ack_o(ack_o), .rdData_o(rdData_o), .respCode_o(respCode_o),
        .busy_o(busy_o), .grantIdx_o(grantIdx_o),
        .rdStart_o(rdStart_o), .rdAddr_o(rdAddr_o),
        .rdDone_i(rdDone_i), .rdData_i(rdData_i), .rdResp_i(rdResp_i),
        .wrStart_o(wrStart_o), .wrAddr_o(wrAddr_o), .wrData_o(wrData_o),
        .wrDone_i(wrDone_i), .wrResp_i(wrResp_i),
        .mstRst_o(mstRst_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int k, input logic wr, input logic [3:0] addr, input logic [31:0] data);
        reqWrite_i[k]          = wr;
        reqAddr_i[k*4 +: 4]    = addr;
        reqData_i[k*32 +: 32]  = data;
    endtask

    task automatic strobe(input logic [3:0] mask);
        req_i = mask;
        tick();
        req_i = '0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (!(rdStart_o || wrStart_o) && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Expect a grant of idx, answer 3 cycles after start, check the ack, optionally re-strobe in RESP
    task automatic serve(input int idx, input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [1:0] rsp, input logic [3:0] restrobe,
                         output int lat);
        wait_start(lat);
        check("start_seen", 64'(rdStart_o | wrStart_o), 64'(1));
        check("grant_idx",  64'(grantIdx_o), 64'(idx));
        check("start_dir",  64'({wrStart_o, rdStart_o}), wr ? 64'(2) : 64'(1));
        check("start_addr", wr ? 64'(wrAddr_o) : 64'(rdAddr_o), 64'(addr));
        if (wr) check("start_wdata", 64'(wrData_o), 64'(wd));
        tick();
        check("start_1cyc", 64'(rdStart_o | wrStart_o), 64'(0));
        tick();
        tick();
        rdData_i = rd;
        if (wr) begin
            wrDone_i = 1'b1;
            wrResp_i = rsp;
        end else begin
            rdDone_i = 1'b1;
            rdResp_i = rsp;
        end
        tick();
        rdDone_i = 1'b0;
        wrDone_i = 1'b0;
        check("ack",       64'(ack_o), 64'(1) << idx);
        check("ack_rdata", 64'(rdData_o), wr ? 64'(0) : 64'(rd));
        check("ack_resp",  64'(respCode_o), 64'(rsp));
        check("ack_busy",  64'(busy_o), 64'(1));
        req_i = restrobe;
        tick();
        req_i = '0;
        check("ack_1cyc",  64'(ack_o), 64'(0));
    endtask

    initial begin
        int lat;
        int n;
        logic seen_ack;
        logic seen_mst;

        // Reset state
        repeat (3) tick();
        check("rst_ack",   64'(ack_o), 64'(0));
        check("rst_busy",  64'(busy_o), 64'(0));
        check("rst_start", 64'({rdStart_o, wrStart_o}), 64'(0));
        check("rst_data",  64'({rdData_o, respCode_o}), 64'(0));
        check("rst_grant", 64'(grantIdx_o), 64'(0));
        check("rst_mst",   64'(mstRst_o), 64'(0));
        rst = 1'b1;
        tick();

        // 1: single read, best-case latency
        set_cmd(0, 1'b0, 4'd4, 32'h0);
        strobe(4'b0001);
        serve(0, 1'b0, 4'd4, 32'h0, 32'hDEADBEEF, 2'b00, 4'b0000, lat);
        check("t1_latency", 64'(lat), 64'(1));

        // 2: single write, rdData_o forced to 0 even with garbage on the read bus
        set_cmd(2, 1'b1, 4'd8, 32'h12345678);
        strobe(4'b0100);
        serve(2, 1'b1, 4'd8, 32'h12345678, 32'hA5A5A5A5, 2'b10, 4'b0000, lat);

        // 3: all four at once after reset, then 1 and 3
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) set_cmd(k, k[0], 4'(k + 1), 32'h10000000 + k);
        strobe(4'b1111);
        for (int k = 0; k < 4; k++)
            serve(k, k[0], 4'(k + 1), 32'h10000000 + k, 32'hC0DE0000 + k, 2'(k), 4'b0000, lat);
        strobe(4'b1010);
        serve(1, 1'b1, 4'd2, 32'h10000001, 32'h0, 2'b00, 4'b0000, lat);
        serve(3, 1'b1, 4'd4, 32'h10000003, 32'h0, 2'b01, 4'b0000, lat);

        // 4: re-strobes in RESP keep 0 and 1 alternating
        set_cmd(0, 1'b0, 4'd6, 32'h0);
        set_cmd(1, 1'b1, 4'd7, 32'h77776666);
        strobe(4'b0011);
        serve(0, 1'b0, 4'd6, 32'h0, 32'h00000A00, 2'b00, 4'b0001, lat);
        serve(1, 1'b1, 4'd7, 32'h77776666, 32'h0, 2'b00, 4'b0010, lat);
        serve(0, 1'b0, 4'd6, 32'h0, 32'h00000A02, 2'b01, 4'b0000, lat);
        serve(1, 1'b1, 4'd7, 32'h77776666, 32'h0, 2'b11, 4'b0000, lat);
        check("t4_idle", 64'(busy_o), 64'(0));

        // 5: reset in WAIT, late done ignored, then a normal grant of 1
        set_cmd(0, 1'b0, 4'd5, 32'h0);
        strobe(4'b0001);
        wait_start(lat);
        tick();
        check("t5_in_wait", 64'(busy_o), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("t5_rst_busy",  64'(busy_o), 64'(0));
        check("t5_rst_outs",  64'({ack_o, rdStart_o, wrStart_o, grantIdx_o, rdAddr_o, mstRst_o}), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        rdDone_i = 1'b1;
        rdData_i = 32'hBAD0BAD0;
        tick();
        rdDone_i = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_ack = seen_ack | (|ack_o) | busy_o;
            tick();
        end
        check("t5_late_done", 64'(seen_ack), 64'(0));
        set_cmd(1, 1'b0, 4'd9, 32'h0);
        strobe(4'b0010);
        serve(1, 1'b0, 4'd9, 32'h0, 32'h13579BDF, 2'b00, 4'b0000, lat);
        check("t5_latency", 64'(lat), 64'(1));

        // 6: no done strobe at all
        set_cmd(3, 1'b0, 4'd2, 32'h0);
        strobe(4'b1000);
        wait_start(lat);
        check("t6_start", 64'(rdStart_o), 64'(1));
`ifdef AXIL_ARB_TIMEOUT_EN
        n = 0;
        seen_mst = 1'b0;
        while (ack_o == 4'b0000 && n < 100) begin
            seen_mst = seen_mst | mstRst_o;
            tick();
            n++;
        end
        check("t6_cycles",   64'(n), 64'(17));
        check("t6_ack",      64'(ack_o), 64'(4'b1000));
        check("t6_resp",     64'(respCode_o), 64'(3));
        check("t6_rdata",    64'(rdData_o), 64'(0));
        check("t6_mstrst",   64'(mstRst_o), 64'(1));
        check("t6_mst_early", 64'(seen_mst), 64'(0));
        tick();
        check("t6_mst_1cyc", 64'({mstRst_o, busy_o}), 64'(0));
`else
        seen_ack = 1'b0;
        seen_mst = 1'b0;
        for (n = 0; n < 1000; n++) begin
            tick();
            seen_ack = seen_ack | (|ack_o);
            seen_mst = seen_mst | mstRst_o;
        end
        check("t6_no_ack",   64'(seen_ack), 64'(0));
        check("t6_no_mst",   64'(seen_mst), 64'(0));
        check("t6_stuck",    64'(busy_o), 64'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_recover",  64'(busy_o), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
